// File: rtl/mac_info_pkg.sv
// -----------------------------------------------------------------------------
// mac_info_pkg
// Shared definitions for the Ethernet MAC transmit buffer-descriptor (BD) ring:
//   - Tx BD status-word bit positions (RDY, IRQ, WRAP, PAD, CRC, status[8:0])
//   - done_status field positions and the frame-error helper
//   - BD ring offset and stride
//   - txbd_state_t, the state encoding of the BD fetch engine
// -----------------------------------------------------------------------------
package mac_info_pkg;

    // Tx BD status word layout: {len[31:16], rdy, irq, wrap, pad, crc, rsvd[10:9], status[8:0]}
    localparam int TXBD_LEN_LSB  = 16;
    localparam int TXBD_RDY      = 15;
    localparam int TXBD_IRQ      = 14;
    localparam int TXBD_WRAP     = 13;
    localparam int TXBD_PAD      = 12;
    localparam int TXBD_CRC      = 11;
    localparam int TXBD_STAT_W   = 9;

    // done_status layout: {under_run, retry[3:0], ret_lim, late_col, defer, c_sense}
    localparam int ST_UNDER_RUN  = 8;
    localparam int ST_RET_LIM    = 3;
    localparam int ST_LATE_COL   = 2;
    localparam int ST_C_SENSE    = 0;

    // Ring placement inside the MAC register window
    localparam logic [31:0] TX_BD_BASE_OFF = 32'h0000_0400;
    localparam int          TXBD_STRIDE    = 8;
    localparam logic [31:0] TXBD_PTR_OFF   = 32'h0000_0004;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STAT,
        S_RD_PTR,
        S_PRESENT,
        S_WAIT_DONE,
        S_WR_STAT,
        S_POLL_WAIT,
        S_ERROR
    } txbd_state_t;

    // Retry count and defer are informational only; they do not mark a failed frame.
    function automatic logic tx_status_error(input logic [TXBD_STAT_W-1:0] st);
        return st[ST_UNDER_RUN] | st[ST_RET_LIM] | st[ST_LATE_COL] | st[ST_C_SENSE];
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// -----------------------------------------------------------------------------
// wb_single_master
// Single-transfer Wishbone master. A request is accepted while the bus is idle;
// cyc/stb stay high until ack or err and drop in the following cycle, so two
// back-to-back requests are always separated by one idle cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, req_we           transfer request and direction (held by the client)
//   req_adr, req_dat      address and write data, captured when the cycle starts
//   done, err             one-cycle completion / bus-error indication
//   rdat                  read data, valid together with done
//   wb_*                  Wishbone master signals (sel is always 4'hF)
// -----------------------------------------------------------------------------
module wb_single_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdat,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    logic cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            cyc_q    <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else if (cyc_q) begin
            if (wb_ack_i || wb_err_i) begin
                cyc_q   <= 1'b0;
                wb_we_o <= 1'b0;
            end
        end else if (req) begin
            cyc_q    <= 1'b1;
            wb_we_o  <= req_we;
            wb_adr_o <= req_adr;
            wb_dat_o <= req_we ? req_dat : 32'h0;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = 4'hF;

    // An error wins over a simultaneous ack.
    assign err  = cyc_q & wb_err_i;
    assign done = cyc_q & wb_ack_i & ~wb_err_i;
    assign rdat = wb_dat_i;

endmodule

// File: rtl/eth_txbd_fetch.sv
// -----------------------------------------------------------------------------
// eth_txbd_fetch
// Walks the Tx buffer-descriptor ring at MAC_BASE + 0x400. For each ready BD it
// reads the status and pointer words, hands one frame descriptor to the Tx data
// mover, waits for that frame's completion status, writes the BD back with rdy
// cleared, pulses the TXB/TXE interrupts and advances the ring index.
// Build option: define TXBD_STATS_EN to add saturating frames_ok/frames_err
// counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   txen, tx_bd_num            enable and ring size (0 = disabled)
//   wb_*                       Wishbone master
//   desc_valid/ready/len/ptr/pad/crc   frame descriptor to the data mover
//   done_valid, done_status    frame completion from the data mover
//   irq_txb, irq_txe           one-cycle interrupt pulses
//   bd_idx                     current ring index
//   bus_err                    sticky Wishbone error flag
//   frames_ok, frames_err      (TXBD_STATS_EN only) completion counters
// -----------------------------------------------------------------------------
module eth_txbd_fetch
    import mac_info_pkg::*;
#(
    parameter logic [31:0] MAC_BASE = 32'h0000_0000,
    parameter int unsigned POLL_GAP = 16,
    parameter int unsigned MAX_BD   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        txen,
    input  logic [7:0]  tx_bd_num,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [15:0] desc_len,
    output logic [31:0] desc_ptr,
    output logic        desc_pad,
    output logic        desc_crc,
    input  logic        done_valid,
    input  logic [8:0]  done_status,
    output logic        irq_txb,
    output logic        irq_txe,
    output logic [6:0]  bd_idx,
    output logic        bus_err
`ifdef TXBD_STATS_EN
   ,output logic [15:0] frames_ok,
    output logic [15:0] frames_err
`endif
);

    txbd_state_t state_q, state_d;

    logic [31:0]            stat_q;
    logic [31:0]            ptr_q;
    logic [TXBD_STAT_W-1:0] done_stat_q;
    logic [6:0]             bd_idx_q;
    logic [15:0]            poll_cnt_q;

    logic        bus_req, bus_we, bus_done, bus_fail;
    logic [31:0] bus_adr, bus_wdat, bus_rdat;

    logic [31:0] bd_addr;
    logic [31:0] wr_word;
    logic [7:0]  eff_num;
    logic [7:0]  idx_inc;
    logic        frame_err;

    // ------------------------------------------------------------------------
    // Address / data helpers
    // ------------------------------------------------------------------------
    assign bd_addr   = MAC_BASE + TX_BD_BASE_OFF + 32'(bd_idx_q) * 32'(TXBD_STRIDE);
    assign eff_num   = (32'(tx_bd_num) > MAX_BD) ? 8'(MAX_BD) : tx_bd_num;
    assign idx_inc   = {1'b0, bd_idx_q} + 8'd1;
    assign frame_err = tx_status_error(done_stat_q);

    // Write-back keeps len/irq/wrap/pad/crc, hands the BD back to software and
    // replaces the status field with the completion status.
    always_comb begin
        wr_word                    = stat_q;
        wr_word[TXBD_RDY]          = 1'b0;
        wr_word[TXBD_STAT_W-1:0]   = done_stat_q;
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        bus_req  = 1'b0;
        bus_we   = 1'b0;
        bus_adr  = bd_addr;
        bus_wdat = wr_word;

        unique case (state_q)
            S_IDLE: begin
                if (txen && tx_bd_num != 8'd0 && !bus_err) state_d = S_RD_STAT;
            end
            S_RD_STAT: begin
                bus_req = 1'b1;
                if (bus_fail)      state_d = S_ERROR;
                else if (bus_done) state_d = bus_rdat[TXBD_RDY] ? S_RD_PTR : S_POLL_WAIT;
            end
            S_RD_PTR: begin
                bus_req = 1'b1;
                bus_adr = bd_addr + TXBD_PTR_OFF;
                if (bus_fail)      state_d = S_ERROR;
                else if (bus_done) state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (desc_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_valid) state_d = S_WR_STAT;
            end
            S_WR_STAT: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
                if (bus_fail)      state_d = S_ERROR;
                else if (bus_done) state_d = txen ? S_RD_STAT : S_IDLE;
            end
            S_POLL_WAIT: begin
                if (!txen)                                state_d = S_IDLE;
                else if (poll_cnt_q == 16'(POLL_GAP - 1)) state_d = S_RD_STAT;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q      <= '0;
            ptr_q       <= '0;
            done_stat_q <= '0;
            bd_idx_q    <= '0;
            poll_cnt_q  <= '0;
            irq_txb     <= 1'b0;
            irq_txe     <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            irq_txb <= 1'b0;
            irq_txe <= 1'b0;
            if (bus_fail) bus_err <= 1'b1;

            // Counter runs only while waiting, so each POLL_WAIT visit lasts POLL_GAP cycles.
            if (state_q == S_POLL_WAIT) poll_cnt_q <= poll_cnt_q + 16'd1;
            else                        poll_cnt_q <= '0;

            unique case (state_q)
                S_RD_STAT: if (bus_done) stat_q <= bus_rdat;
                S_RD_PTR:  if (bus_done) ptr_q  <= bus_rdat;
                S_WAIT_DONE: if (done_valid) done_stat_q <= done_status;
                S_WR_STAT: begin
                    if (bus_done) begin
                        irq_txb <= stat_q[TXBD_IRQ] & ~frame_err;
                        irq_txe <= stat_q[TXBD_IRQ] &  frame_err;
                        // ">=" also recovers when tx_bd_num shrank below the current index.
                        if (stat_q[TXBD_WRAP] || idx_inc >= eff_num) bd_idx_q <= '0;
                        else                                         bd_idx_q <= idx_inc[6:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TXBD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_ok  <= '0;
            frames_err <= '0;
        end else if (state_q == S_WR_STAT && bus_done) begin
            if (frame_err) begin
                if (frames_err != 16'hFFFF) frames_err <= frames_err + 16'd1;
            end else begin
                if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign desc_valid = (state_q == S_PRESENT);
    assign desc_len   = stat_q[31:TXBD_LEN_LSB];
    assign desc_pad   = stat_q[TXBD_PAD];
    assign desc_crc   = stat_q[TXBD_CRC];
    assign desc_ptr   = ptr_q;
    assign bd_idx     = bd_idx_q;

    wb_single_master u_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus_req),
        .req_we   (bus_we),
        .req_adr  (bus_adr),
        .req_dat  (bus_wdat),
        .done     (bus_done),
        .err      (bus_fail),
        .rdat     (bus_rdat),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

endmodule

// File: tb/tb_eth_txbd_fetch.sv
// -----------------------------------------------------------------------------
// tb_eth_txbd_fetch
// Bench for eth_txbd_fetch. A behavioural model holds the BD ring as a small
// memory, answers Wishbone cycles with zero wait states, and predicts the ring
// index, the write-back word and the interrupt pulses from the BD rules. One
// compare process checks the DUT against it every cycle; directed scenarios
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_eth_txbd_fetch;

    localparam int POLL_GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        txen;
    logic [7:0]  tx_bd_num;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic        desc_valid, desc_ready;
    logic [15:0] desc_len;
    logic [31:0] desc_ptr;
    logic        desc_pad, desc_crc;
    logic        done_valid;
    logic [8:0]  done_status;
    logic        irq_txb, irq_txe;
    logic [6:0]  bd_idx;
    logic        bus_err;

    always #5 clk = ~clk;

    eth_txbd_fetch #(
        .MAC_BASE (32'h0000_0000),
        .POLL_GAP (POLL_GAP),
        .MAX_BD   (128)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .txen        (txen),
        .tx_bd_num   (tx_bd_num),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_len    (desc_len),
        .desc_ptr    (desc_ptr),
        .desc_pad    (desc_pad),
        .desc_crc    (desc_crc),
        .done_valid  (done_valid),
        .done_status (done_status),
        .irq_txb     (irq_txb),
        .irq_txe     (irq_txe),
        .bd_idx      (bd_idx),
        .bus_err     (bus_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model state: BD ring memory and predictions
    // ------------------------------------------------------------------------
    logic [31:0] stat_mem [4];
    logic [31:0] ptr_mem  [4];
    int          m_idx;
    bit          m_err;
    bit          exp_txb, exp_txe;
    logic [8:0]  m_status;
    bit          inject_err_ptr;
    int          cyc_cnt;
    int          n_reads, n_writes, n_poll_reads;
    logic [31:0] last_radr, last_wadr, last_wdat;
    bit          poll_pending;
    int          poll_cycle;

    function automatic logic [31:0] bd_addr(input int idx);
        return 32'h400 + 32'(idx) * 32'd8;
    endfunction

    function automatic int ring_size();
        int n = int'(tx_bd_num);
        return (n > 128) ? 128 : n;
    endfunction

    initial begin : model_compare
        logic [31:0] cur, exp_w;
        int          gap;
        bit          bad;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            if (!rst_n) begin
                m_idx = 0; m_err = 0; exp_txb = 0; exp_txe = 0; poll_pending = 0;
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
            end else begin
                check("sel", 32'(wb_sel_o), 32'hF);
                check("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
                check("bd_idx", 32'(bd_idx), m_idx);
                check("irq_txb", 32'(irq_txb), 32'(exp_txb));
                check("irq_txe", 32'(irq_txe), 32'(exp_txe));
                check("bus_err", 32'(bus_err), 32'(m_err));
                if (m_err) begin
                    check("cyc_after_err", 32'(wb_cyc_o), 32'h0);
                    check("desc_after_err", 32'(desc_valid), 32'h0);
                end
                if (desc_valid) begin
                    check("desc_len", 32'(desc_len), 32'(stat_mem[m_idx][31:16]));
                    check("desc_ptr", desc_ptr, ptr_mem[m_idx]);
                    check("desc_pad", 32'(desc_pad), 32'(stat_mem[m_idx][12]));
                    check("desc_crc", 32'(desc_crc), 32'(stat_mem[m_idx][11]));
                    check("bus_idle_present", 32'(wb_cyc_o), 32'h0);
                end

                exp_txb = 0;
                exp_txe = 0;
                if (wb_ack_i || wb_err_i) begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end else if (wb_cyc_o && !m_err) begin
                    cur = stat_mem[m_idx];
                    if (wb_we_o) begin
                        exp_w = {cur[31:16], 1'b0, cur[14:9], m_status};
                        check("wr_adr", wb_adr_o, bd_addr(m_idx));
                        check("wr_dat", wb_dat_o, exp_w);
                        last_wadr = wb_adr_o;
                        last_wdat = wb_dat_o;
                        n_writes++;
                        bad = m_status[8] | m_status[3] | m_status[2] | m_status[0];
                        exp_txb = cur[14] && !bad;
                        exp_txe = cur[14] && bad;
                        stat_mem[m_idx] = wb_dat_o;
                        m_idx = (cur[13] || m_idx + 1 >= ring_size()) ? 0 : m_idx + 1;
                        wb_ack_i = 1'b1;
                    end else if (wb_adr_o == bd_addr(m_idx) + 32'd4) begin
                        if (inject_err_ptr) begin
                            wb_err_i = 1'b1;
                            m_err    = 1;
                        end else begin
                            wb_dat_i = ptr_mem[m_idx];
                            wb_ack_i = 1'b1;
                        end
                        last_radr = wb_adr_o;
                        n_reads++;
                    end else begin
                        check("rd_adr", wb_adr_o, bd_addr(m_idx));
                        if (poll_pending) begin
                            gap = cyc_cnt - poll_cycle - 1;
                            check("poll_gap_min", 32'(gap >= POLL_GAP), 32'h1);
                            check("poll_gap_max", 32'(gap <= POLL_GAP + 4), 32'h1);
                        end
                        poll_pending = !cur[15];
                        poll_cycle   = cyc_cnt;
                        if (!cur[15]) n_poll_reads++;
                        wb_dat_i  = cur;
                        wb_ack_i  = 1'b1;
                        last_radr = wb_adr_o;
                        n_reads++;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all sample/drive 2 time units after the falling edge)
    // ------------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_desc(input string name);
        int t = 0;
        while (!desc_valid && t < 300) begin tick(); t++; end
        check({name, "_desc_seen"}, 32'(desc_valid), 32'h1);
    endtask

    task automatic wait_write(input string name);
        int start = n_writes;
        int t = 0;
        while (n_writes == start && t < 300) begin tick(); t++; end
        check({name, "_write_seen"}, 32'(n_writes != start), 32'h1);
    endtask

    task automatic run_frame(input logic [8:0] st, input int hold,
                             input logic [15:0] len, input logic [31:0] ptr);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(desc_valid), 32'h1);
            check("hold_len", 32'(desc_len), 32'(len));
            check("hold_ptr", desc_ptr, ptr);
            check("hold_no_bus", 32'(wb_cyc_o), 32'h0);
        end
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
        tick(3);
        m_status    = st;
        done_status = st;
        done_valid  = 1'b1;
        tick();
        done_valid  = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin : stimulus
        int t, r0, p0;
        rst_n = 1'b0; txen = 1'b0; tx_bd_num = 8'd0;
        desc_ready = 1'b0; done_valid = 1'b0; done_status = 9'h0;
        inject_err_ptr = 0; m_status = 9'h0;
        for (int i = 0; i < 4; i++) begin stat_mem[i] = 32'h0; ptr_mem[i] = 32'h0; end
        stat_mem[0] = 32'h003C_C000;
        ptr_mem[0]  = 32'h0000_1000;

        // Reset values
        tick(3);
        check("rst_cyc", 32'(wb_cyc_o), 32'h0);
        check("rst_sel", 32'(wb_sel_o), 32'hF);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_desc_valid", 32'(desc_valid), 32'h0);
        check("rst_desc_len", 32'(desc_len), 32'h0);
        check("rst_bd_idx", 32'(bd_idx), 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_irq", 32'({irq_txb, irq_txe}), 32'h0);
        rst_n = 1'b1;
        tick(2);
        tx_bd_num = 8'd2;
        txen      = 1'b1;

        // 1: first frame, no error, irq set
        wait_desc("t1");
        check("t1_len", 32'(desc_len), 32'd60);
        check("t1_ptr", desc_ptr, 32'h0000_1000);
        check("t1_padcrc", 32'({desc_pad, desc_crc}), 32'h0);
        run_frame(9'h000, 0, 16'd60, 32'h1000);
        wait_write("t1");
        check("t1_wadr", last_wadr, 32'h0000_0400);
        check("t1_wdat", last_wdat, 32'h003C_4000);
        tick();
        check("t1_irq_txb", 32'(irq_txb), 32'h1);
        check("t1_irq_txe", 32'(irq_txe), 32'h0);
        check("t1_bd_idx", 32'(bd_idx), 32'd1);

        // 2: BD1 with wrap, pad, crc; retry/defer are not errors
        stat_mem[1] = 32'h0040_F800;
        ptr_mem[1]  = 32'h0000_2000;
        wait_desc("t2");
        check("t2_len", 32'(desc_len), 32'd64);
        check("t2_ptr", desc_ptr, 32'h0000_2000);
        check("t2_padcrc", 32'({desc_pad, desc_crc}), 32'h3);
        run_frame(9'h012, 0, 16'd64, 32'h2000);
        wait_write("t2");
        check("t2_wadr", last_wadr, 32'h0000_0408);
        check("t2_wdat", last_wdat, 32'h0040_7812);
        r0 = n_reads;
        tick();
        check("t2_irq_txb", 32'(irq_txb), 32'h1);
        check("t2_bd_idx", 32'(bd_idx), 32'd0);
        t = 0;
        while (n_reads == r0 && t < 100) begin tick(); t++; end
        check("t2_next_rd_adr", last_radr, 32'h0000_0400);

        // 3: BD0 not ready -> periodic polling, then software arms it
        p0 = n_poll_reads;
        tick(60);
        check("t3_polls", 32'(n_poll_reads - p0 >= 2), 32'h1);
        stat_mem[0] = 32'h0050_C000;
        ptr_mem[0]  = 32'h0000_3000;
        wait_desc("t3");
        check("t3_len", 32'(desc_len), 32'd80);
        check("t3_ptr", desc_ptr, 32'h0000_3000);

        // 5 + 4: hold desc_ready low for 10 cycles, then under-run completion
        run_frame(9'h100, 10, 16'd80, 32'h3000);
        wait_write("t4");
        check("t4_wadr", last_wadr, 32'h0000_0400);
        check("t4_wdat", last_wdat, 32'h0050_4100);
        tick();
        check("t4_irq_txe", 32'(irq_txe), 32'h1);
        check("t4_irq_txb", 32'(irq_txb), 32'h0);
        check("t4_bd_idx", 32'(bd_idx), 32'd1);

        // Last BD without wrap: index returns to 0 at the ring size
        stat_mem[1] = 32'h0020_D000;
        ptr_mem[1]  = 32'h0000_4000;
        wait_desc("t7");
        check("t7_len", 32'(desc_len), 32'd32);
        check("t7_padcrc", 32'({desc_pad, desc_crc}), 32'h2);
        run_frame(9'h004, 0, 16'd32, 32'h4000);
        wait_write("t7");
        check("t7_wadr", last_wadr, 32'h0000_0408);
        check("t7_wdat", last_wdat, 32'h0020_5004);
        tick();
        check("t7_irq_txe", 32'(irq_txe), 32'h1);
        check("t7_bd_idx", 32'(bd_idx), 32'd0);

        // 6: bus error during the pointer read
        inject_err_ptr = 1;
        stat_mem[0]    = 32'h0010_C000;
        t = 0;
        while (!m_err && t < 200) begin tick(); t++; end
        check("t6_err_injected", 32'(m_err), 32'h1);
        tick();
        check("t6_bus_err", 32'(bus_err), 32'h1);
        check("t6_cyc_dropped", 32'(wb_cyc_o), 32'h0);
        r0 = n_reads;
        tick(40);
        check("t6_no_more_reads", 32'(n_reads - r0), 32'h0);
        check("t6_desc_valid", 32'(desc_valid), 32'h0);
        check("t6_bus_err_sticky", 32'(bus_err), 32'h1);

        // Reset clears the error and an in-flight cycle drops asynchronously
        rst_n = 1'b0;
        tick(2);
        check("t8_bus_err_clr", 32'(bus_err), 32'h0);
        check("t8_bd_idx_clr", 32'(bd_idx), 32'h0);
        inject_err_ptr = 0;
        rst_n = 1'b1;
        t = 0;
        while (!wb_cyc_o && t < 50) begin tick(); t++; end
        check("t8_cyc_seen", 32'(wb_cyc_o), 32'h1);
        check("t8_first_adr", wb_adr_o, 32'h0000_0400);
        rst_n = 1'b0;
        #1;
        check("t8_cyc_async", 32'(wb_cyc_o), 32'h0);
        check("t8_stb_async", 32'(wb_stb_o), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_txbd_fetch.md
Name: eth_txbd_fetch

Overview:
Wishbone bus-master engine that walks the Ethernet MAC transmit buffer-descriptor ring at MAC_BASE + Tx_bd_base_off (0x400).
- For each BD with rdy=1 it reads the status word and the buffer-pointer word, and presents one frame descriptor to the downstream Tx data mover.
- It then waits for that frame's completion status, writes the BD back with rdy cleared, raises the TXB/TXE interrupt pulses, and advances the ring index.
- It is the stage that feeds the Tx data path and consumes the BD layout defined in the MAC info package.

Parameters:
MAC_BASE, 32'h0000_0000, Wishbone base address of the MAC; BD n is at MAC_BASE+0x400+8n.
POLL_GAP, 16, idle cycles between re-reads of a BD found with rdy=0 (minimum 1).
MAX_BD, 128, ring size limit; tx_bd_num is clamped to this value.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
txen  in  1  mode register TXEN; 0 stops fetching at the next BD boundary
tx_bd_num  in  8  number of Tx BDs; 0 means disabled
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte select, always 4'hF
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error
desc_valid  out  1  descriptor valid
desc_ready  in  1  descriptor accepted
desc_len  out  16  frame length in bytes
desc_ptr  out  32  buffer pointer
desc_pad  out  1  pad enable
desc_crc  out  1  CRC enable
done_valid  in  1  one-cycle completion strobe from the data mover
done_status  in  9  {under_run, retry[3:0], ret_lim, late_col, defer, c_sense}
irq_txb  out  1  one-cycle pulse: frame done without error and BD irq=1
irq_txe  out  1  one-cycle pulse: frame done with error and BD irq=1
bd_idx  out  7  current ring index
bus_err  out  1  sticky; set on wb_err_i

Behaviour:
- Reset values: all outputs 0; wb_sel_o is 4'hF; state is IDLE; internal copy of the BD status word is 0.
- IDLE -> RD_STAT when txen=1, tx_bd_num!=0 and bus_err=0.
- RD_STAT: single read of address MAC_BASE+0x400+8*bd_idx.
  - On ack, latch the word.
  - If bit15 (rdy)=0 -> POLL_WAIT.
  - Otherwise -> RD_PTR.
- RD_PTR: read of address +4. On ack, latch desc_ptr -> PRESENT.
- PRESENT: desc_valid=1; fields are taken from the latched word: len[31:16], pad bit12, crc bit11.
  - desc_valid and all desc_* are held stable until desc_ready=1.
  - On the transfer cycle -> WAIT_DONE.
- WAIT_DONE: wait for done_valid, then latch done_status -> WR_STAT.
  - done_valid in any other state is ignored.
- WR_STAT: single write of the status word to address +0.
  - Write data is the latched word with bit15 cleared and bits[8:0] replaced by done_status.
  - len, irq, wrap, pad and crc are preserved.
  - On ack:
    - error = under_run | ret_lim | late_col | c_sense.
    - irq_txb pulses for one cycle if irq (bit14)=1 and !error; irq_txe pulses for one cycle if irq=1 and error.
    - Advance the index: bd_idx becomes 0 if wrap (bit13)=1 or bd_idx+1 >= eff_num; otherwise bd_idx+1. eff_num = min(tx_bd_num, MAX_BD).
    - Next state is RD_STAT if txen=1, else IDLE.
- POLL_WAIT: count POLL_GAP cycles, then -> RD_STAT with the same index.
  - If txen=0, go to IDLE instead.
- Wishbone protocol: cyc and stb assert together and drop in the cycle after ack or err. One transfer per cycle; no pipelining; no bursts.
- wb_err_i in any bus state: set bus_err, drop cyc/stb, go to ERROR.
  - ERROR is left only by reset.
  - desc_valid stays 0 in ERROR.
- txen falling mid-frame: the current frame completes (PRESENT/WAIT_DONE/WR_STAT finish); the engine then stops.
- tx_bd_num changed so that bd_idx >= eff_num: index wraps to 0 at the next advance.
- rst_n asserted mid-transfer: cyc/stb drop immediately (asynchronous); no write-back occurs.

Optional Feature:
Macro TXBD_STATS_EN.
- Defined: adds outputs frames_ok[15:0] and frames_err[15:0].
  - They increment at each WR_STAT ack according to the error flag.
  - They saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (mac_info_pkg): Tx BD bit positions (RDY=15, IRQ=14, WRAP=13, PAD=12, CRC=11, status field [8:0]), the BD stride of 8, and the state enum txbd_state_t.
- Sub-module wb_single_master: one read or write per request with req/done/err handshake; it drives all wb_* outputs.

Test Plan:
1. tx_bd_num=2, BD0 = 0x003C_C000 (len 60, rdy, irq), ptr 0x1000; done_status=0 -> desc_len=60, desc_ptr=0x1000; write-back 0x003C_4000 to 0x400; irq_txb pulse; bd_idx=1.
2. BD1 with wrap=1 completes -> bd_idx returns to 0; the next read is at 0x400.
3. BD0 rdy=0 -> re-read at 0x400 every 16+ cycles; after software sets rdy=1, fetch proceeds.
4. done_status = 9'h100 (under_run) with irq=1 -> irq_txe pulse, irq_txb=0; write-back bits[8:0]=0x100.
5. Hold desc_ready=0 for 10 cycles -> desc_valid and fields are stable; no bus activity.
6. wb_err_i on RD_PTR -> bus_err=1; cyc drops next cycle; no further bus cycles until rst_n.
